// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - J/K/CE/R drive and Q feedback check for an external JK flip-flop
module jk_excitation_driver #(
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       qfb,
    output logic       j,
    output logic       k,
    output logic       ce,
    output logic       r,
    output logic       mismatch,
    output logic [7:0] bit_cnt,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {INIT, READY, DRIVE, CHECK} state_t;

    state_t state;
    logic   qexp;
    logic   qexp_next;
    logic   j_next;
    logic   k_next;

    assign din_ready = (state == READY);

    always_comb begin
        j_next = 1'b0;
        k_next = 1'b0;
        if (din != qexp) begin
            if (USE_TOGGLE) begin
                j_next = 1'b1;
                k_next = 1'b1;
            end else begin
                j_next = din;
                k_next = ~din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            qexp      <= 1'b0;
            qexp_next <= 1'b0;
            j         <= 1'b0;
            k         <= 1'b0;
            ce        <= 1'b0;
            r         <= 1'b0;
            mismatch  <= 1'b0;
            bit_cnt   <= 8'd0;
            err_cnt   <= 8'd0;
        end else begin
            mismatch <= 1'b0;
            if (clear) begin
                // Restart drops any in-flight bit and holds the flip-flop in reset.
                state   <= INIT;
                qexp    <= 1'b0;
                j       <= 1'b0;
                k       <= 1'b0;
                ce      <= 1'b0;
                r       <= 1'b1;
                bit_cnt <= 8'd0;
                err_cnt <= 8'd0;
            end else begin
                case (state)
                    INIT: begin
                        qexp <= 1'b0;
                        // r low on entry (after rst_n) means the reset pulse is still owed.
                        if (!r) begin
                            r <= 1'b1;
                        end else begin
                            r     <= 1'b0;
                            state <= READY;
                        end
                    end
                    READY: begin
                        if (din_valid) begin
                            qexp_next <= din;
                            j         <= j_next;
                            k         <= k_next;
                            ce        <= 1'b1;
                            state     <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        j     <= 1'b0;
                        k     <= 1'b0;
                        ce    <= 1'b0;
                        state <= CHECK;
                    end
                    CHECK: begin
                        bit_cnt <= bit_cnt + 8'd1;
                        if (qfb != qexp_next) begin
                            mismatch <= 1'b1;
                            if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
                        end
                        qexp  <= qfb;
                        state <= READY;
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - scoreboard bench for jk_excitation_driver, set/reset and toggle forms
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] din = '0;
    logic [1:0] din_valid = '0;
    logic [1:0] din_ready;
    logic [1:0] qfb;
    logic [1:0] j, k, ce, r, mismatch;
    logic [7:0] bit_cnt0, err_cnt0, bit_cnt1, err_cnt1;
    logic [1:0] q_ff = '0;
    logic [1:0] stuck = '0;
    logic [1:0] exp_q = '0;

    typedef struct packed {
        logic j;
        logic k;
        logic mism;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.USE_TOGGLE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .qfb(qfb[0]), .j(j[0]), .k(k[0]), .ce(ce[0]), .r(r[0]),
        .mismatch(mismatch[0]), .bit_cnt(bit_cnt0), .err_cnt(err_cnt0)
    );

    jk_excitation_driver #(.USE_TOGGLE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .qfb(qfb[1]), .j(j[1]), .k(k[1]), .ce(ce[1]), .r(r[1]),
        .mismatch(mismatch[1]), .bit_cnt(bit_cnt1), .err_cnt(err_cnt1)
    );

    // Ideal external JK flip-flops with CE and synchronous reset (reset wins).
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) q_ff[i] <= 1'b0;
            else if (r[i]) q_ff[i] <= 1'b0;
            else if (ce[i]) begin
                case ({j[i], k[i]})
                    2'b01:   q_ff[i] <= 1'b0;
                    2'b10:   q_ff[i] <= 1'b1;
                    2'b11:   q_ff[i] <= ~q_ff[i];
                    default: q_ff[i] <= q_ff[i];
                endcase
            end
        end
    end

    assign qfb = q_ff & ~stuck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int sel, input bit b, input bit toggle);
        exp_t e;
        exp_t got;
        int   n;
        n = 0;
        while (din_ready[sel] !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("ready_wait", {31'd0, din_ready[sel]}, 32'd1);
        e.j = 1'b0;
        e.k = 1'b0;
        if (b != exp_q[sel]) begin
            e.j = toggle ? 1'b1 : b;
            e.k = toggle ? 1'b1 : ~b;
        end
        e.mism = stuck[sel] ? (b != 1'b0) : 1'b0;
        sb.push_back(e);
        din[sel] = b;
        din_valid[sel] = 1'b1;
        step();
        din_valid[sel] = 1'b0;
        got = sb[0];
        check("drive_ce", {31'd0, ce[sel]}, 32'd1);
        check("drive_jk", {30'd0, j[sel], k[sel]}, {30'd0, got.j, got.k});
        step();
        check("check_idle", {29'd0, ce[sel], j[sel], k[sel]}, 32'd0);
        step();
        got = sb.pop_front();
        check("mismatch", {31'd0, mismatch[sel]}, {31'd0, got.mism});
        check("ready_after", {31'd0, din_ready[sel]}, 32'd1);
        exp_q[sel] = stuck[sel] ? 1'b0 : b;
    endtask

    initial begin
        bit s1 [4];
        bit s2 [3];
        s1 = '{1'b1, 1'b0, 1'b0, 1'b1};
        s2 = '{1'b1, 1'b1, 1'b0};

        // Reset state and INIT sequence
        step();
        check("rst_outs", {24'd0, j, k, ce, r}, 32'd0);
        check("rst_misc", {24'd0, mismatch, din_ready, 2'b00}, 32'd0);
        check("rst_cnt", {bit_cnt0, err_cnt0, bit_cnt1, err_cnt1}, 32'd0);
        rst_n = 1'b1;
        step();
        check("init_r", {30'd0, r}, 32'd3);
        check("init_notready", {30'd0, din_ready}, 32'd0);
        step();
        check("init_r_drop", {30'd0, r}, 32'd0);
        check("init_ready", {30'd0, din_ready}, 32'd3);

        // Set/reset form, ideal flip-flop
        for (int i = 0; i < 4; i++) send_bit(0, s1[i], 1'b0);
        check("sr_bitcnt", {24'd0, bit_cnt0}, 32'd4);
        check("sr_errcnt", {24'd0, err_cnt0}, 32'd0);

        // Toggle form, ideal flip-flop
        for (int i = 0; i < 3; i++) send_bit(1, s2[i], 1'b1);
        check("tg_bitcnt", {24'd0, bit_cnt1}, 32'd3);
        check("tg_errcnt", {24'd0, err_cnt1}, 32'd0);

        // Stuck-at-0 flip-flop, three mismatches
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_r", {31'd0, r[0]}, 32'd1);
        check("clr_cnt", {bit_cnt0, err_cnt0}, 32'd0);
        exp_q = '0;
        stuck[0] = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b0);
        check("stk_bitcnt", {24'd0, bit_cnt0}, 32'd3);
        check("stk_errcnt", {24'd0, err_cnt0}, 32'd3);
        stuck[0] = 1'b0;

        // Clear during DRIVE discards the bit
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        exp_q = '0;
        din[0] = 1'b1;
        din_valid[0] = 1'b1;
        step();
        din_valid[0] = 1'b0;
        check("cd_ce_on", {31'd0, ce[0]}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("cd_ce_off", {31'd0, ce[0]}, 32'd0);
        check("cd_r", {31'd0, r[0]}, 32'd1);
        step();
        check("cd_r_drop", {31'd0, r[0]}, 32'd0);
        check("cd_ready", {31'd0, din_ready[0]}, 32'd1);
        check("cd_bitcnt", {24'd0, bit_cnt0}, 32'd0);

        // 300 stuck bits: error saturates, bit count wraps
        stuck[0] = 1'b1;
        exp_q[0] = q_ff[0] & ~stuck[0];
        for (int i = 0; i < 300; i++) send_bit(0, 1'b1, 1'b0);
        check("sat_errcnt", {24'd0, err_cnt0}, 32'd255);
        check("wrap_bitcnt", {24'd0, bit_cnt0}, 32'd44);
        stuck[0] = 1'b0;

        // Asynchronous reset mid-DRIVE drops CE without an edge
        din[0] = 1'b1;
        din_valid[0] = 1'b1;
        step();
        din_valid[0] = 1'b0;
        check("ar_ce_on", {31'd0, ce[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_ce_off", {24'd0, j, k, ce, r}, 32'd0);
        check("ar_ready", {30'd0, din_ready}, 32'd0);
        check("ar_cnt", {bit_cnt0, err_cnt0}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("ar_init_r", {31'd0, r[0]}, 32'd1);
        step();
        check("ar_ready_back", {31'd0, din_ready[0]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
